// File: rtl/seg7led_dynamic.sv
// Multiplexed 7-segment driver: scans DIGITS digits over one shared segment bus, with PWM, blink and dp.
// Latency: outputs registered 1 clk behind the scan counters; ctrl_readdata valid 1 clk after ctrl_read.
// Backpressure: none; the bus is always ready and every write/read strobe completes in one cycle.
module seg7led_dynamic #(
    parameter int DIGITS         = 4,
    parameter bit SEG_ACTIVE_LOW = 1'b1,
    parameter bit DIG_ACTIVE_LOW = 1'b1,
    parameter int PRESCALE       = 1000,
    parameter int BLINK_FRAMES   = 64
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [1:0]        ctrl_address,
    input  logic              ctrl_write,
    input  logic [31:0]       ctrl_writedata,
    input  logic              ctrl_read,
    output logic [31:0]       ctrl_readdata,
    output logic [6:0]        seg,
    output logic              seg_dp,
    output logic [DIGITS-1:0] dig
);

    localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam int DW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam int FW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

    localparam logic [PW-1:0]     PC_LAST = PW'(PRESCALE - 1);
    localparam logic [DW-1:0]     D_LAST  = DW'(DIGITS - 1);
    localparam logic [FW-1:0]     F_LAST  = FW'(BLINK_FRAMES - 1);
    localparam logic [6:0]        SEG_OFF = {7{SEG_ACTIVE_LOW}};
    localparam logic [DIGITS-1:0] DIG_OFF = {DIGITS{DIG_ACTIVE_LOW}};

    // Active-high glyph, bit 6 = a .. bit 0 = g.
    function automatic logic [6:0] hex_glyph(input logic [3:0] v);
        case (v)
            4'h0: hex_glyph = 7'h7E;
            4'h1: hex_glyph = 7'h30;
            4'h2: hex_glyph = 7'h6D;
            4'h3: hex_glyph = 7'h79;
            4'h4: hex_glyph = 7'h33;
            4'h5: hex_glyph = 7'h5B;
            4'h6: hex_glyph = 7'h5F;
            4'h7: hex_glyph = 7'h70;
            4'h8: hex_glyph = 7'h7F;
            4'h9: hex_glyph = 7'h7B;
            4'hA: hex_glyph = 7'h77;
            4'hB: hex_glyph = 7'h1F;
            4'hC: hex_glyph = 7'h4E;
            4'hD: hex_glyph = 7'h3D;
            4'hE: hex_glyph = 7'h4F;
            default: hex_glyph = 7'h47;
        endcase
    endfunction

    // Control registers
    logic [4*DIGITS-1:0] data_q;
    logic [DIGITS-1:0]   on_q;
    logic [DIGITS-1:0]   dp_q;
    logic [3:0]          bright_q;
    logic [DIGITS-1:0]   blink_q;
    logic [31:0]         rdata_q, rdata_d;

    // Scan counters
    logic [PW-1:0] pc_q, pc_d;
    logic [3:0]    tick_q, tick_d;
    logic [DW-1:0] didx_q, didx_d;
    logic [FW-1:0] frame_q, frame_d;
    logic          bp_q, bp_d;
    logic          pc_wrap, tick_wrap, d_wrap, f_wrap;

    // Per-slot snapshot, so bus writes never disturb the digit being shown
    logic [6:0] slot_glyph_q;
    logic       slot_dp_q, slot_on_q, slot_blink_q;
    logic       slot_load;

    // Output stage
    logic              en;
    logic [DIGITS-1:0] onehot;
    logic [6:0]        seg_q, seg_d;
    logic              dp_out_q, dp_out_d;
    logic [DIGITS-1:0] dig_q, dig_d;

    // Writedata bits beyond the implemented fields are deliberately dropped.
    logic unused_wdata;
    assign unused_wdata = ^ctrl_writedata;

    // Register file writes
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            data_q   <= '0;
            on_q     <= '1;
            dp_q     <= '0;
            bright_q <= 4'hF;
            blink_q  <= '0;
        end else if (ctrl_write) begin
            case (ctrl_address)
                2'd0: data_q <= ctrl_writedata[4*DIGITS-1:0];
                2'd1: on_q   <= ctrl_writedata[DIGITS-1:0];
                2'd2: dp_q   <= ctrl_writedata[DIGITS-1:0];
                default: begin
                    bright_q <= ctrl_writedata[3:0];
                    blink_q  <= ctrl_writedata[8 +: DIGITS];
                end
            endcase
        end
    end

    // Readback mux; registered values give old data on a same-cycle write
    always_comb begin
        rdata_d = '0;
        case (ctrl_address)
            2'd0: rdata_d[4*DIGITS-1:0] = data_q;
            2'd1: rdata_d[DIGITS-1:0]   = on_q;
            2'd2: rdata_d[DIGITS-1:0]   = dp_q;
            default: begin
                rdata_d[3:0]        = bright_q;
                rdata_d[8 +: DIGITS] = blink_q;
            end
        endcase
    end

    // Read data register, holds until the next read strobe
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) rdata_q <= '0;
        else if (ctrl_read) rdata_q <= rdata_d;
    end

    // Prescaler / tick / digit / frame / blink-phase next state
    always_comb begin
        pc_wrap   = (pc_q == PC_LAST);
        tick_wrap = pc_wrap && (tick_q == 4'd15);
        d_wrap    = tick_wrap && (didx_q == D_LAST);
        f_wrap    = d_wrap && (frame_q == F_LAST);
        pc_d      = pc_wrap ? '0 : pc_q + 1'b1;
        tick_d    = pc_wrap ? tick_q + 1'b1 : tick_q;
        didx_d    = didx_q;
        if (tick_wrap) didx_d = d_wrap ? '0 : didx_q + 1'b1;
        frame_d   = frame_q;
        if (d_wrap) frame_d = f_wrap ? '0 : frame_q + 1'b1;
        bp_d      = f_wrap ? ~bp_q : bp_q;
    end

    // Scan counter registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pc_q    <= '0;
            tick_q  <= '0;
            didx_q  <= '0;
            frame_q <= '0;
            bp_q    <= 1'b0;
        end else begin
            pc_q    <= pc_d;
            tick_q  <= tick_d;
            didx_q  <= didx_d;
            frame_q <= frame_d;
            bp_q    <= bp_d;
        end
    end

    assign slot_load = (pc_q == '0) && (tick_q == 4'd0);

    // Snapshot digit attributes at the start of its slot (tick 0 is blank anyway)
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            slot_glyph_q <= '0;
            slot_dp_q    <= 1'b0;
            slot_on_q    <= 1'b0;
            slot_blink_q <= 1'b0;
        end else if (slot_load) begin
            slot_glyph_q <= hex_glyph(data_q[{didx_q, 2'b00} +: 4]);
            slot_dp_q    <= dp_q[didx_q];
            slot_on_q    <= on_q[didx_q];
            slot_blink_q <= blink_q[didx_q];
        end
    end

    // Enable: tick 0 reserved for anti-ghosting, brightness compared live
    always_comb begin
        en       = slot_on_q && !(slot_blink_q && bp_q) && (tick_q != 4'd0) && (tick_q <= bright_q);
        onehot   = DIGITS'(1) << didx_q;
        seg_d    = en ? (slot_glyph_q ^ SEG_OFF) : SEG_OFF;
        dp_out_d = en ? (slot_dp_q ^ SEG_ACTIVE_LOW) : SEG_ACTIVE_LOW;
        dig_d    = en ? (onehot ^ DIG_OFF) : DIG_OFF;
    end

    // Registered pin drivers; reset forces the off levels immediately
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            seg_q    <= SEG_OFF;
            dp_out_q <= SEG_ACTIVE_LOW;
            dig_q    <= DIG_OFF;
        end else begin
            seg_q    <= seg_d;
            dp_out_q <= dp_out_d;
            dig_q    <= dig_d;
        end
    end

    assign seg           = seg_q;
    assign seg_dp        = dp_out_q;
    assign dig           = dig_q;
    assign ctrl_readdata = rdata_q;

endmodule

// File: tb/tb_seg7led_dynamic.sv
// Directed bench for seg7led_dynamic: DIGITS=4, PRESCALE=2, BLINK_FRAMES=2, active-low pins.
// Scan state is tracked by a bench-side clock counter so window/frame positions are known.
// Each scenario task drives the bus and compares counts/levels against hand-derived constants.
module tb_seg7led_dynamic;

    logic        clk;
    logic        reset_n;
    logic [1:0]  ctrl_address;
    logic        ctrl_write;
    logic [31:0] ctrl_writedata;
    logic        ctrl_read;
    logic [31:0] ctrl_readdata;
    logic [6:0]  seg;
    logic        seg_dp;
    logic [3:0]  dig;

    int checks   = 0;
    int failures = 0;

    seg7led_dynamic #(
        .DIGITS(4), .SEG_ACTIVE_LOW(1'b1), .DIG_ACTIVE_LOW(1'b1),
        .PRESCALE(2), .BLINK_FRAMES(2)
    ) dut (
        .clk(clk), .reset_n(reset_n),
        .ctrl_address(ctrl_address), .ctrl_write(ctrl_write),
        .ctrl_writedata(ctrl_writedata), .ctrl_read(ctrl_read),
        .ctrl_readdata(ctrl_readdata),
        .seg(seg), .seg_dp(seg_dp), .dig(dig)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Clock edges since reset release; at a negedge, outputs reflect scan state s_cnt-1.
    int s_cnt;
    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) s_cnt <= 0;
        else          s_cnt <= s_cnt + 1;
    end

    // Observation accumulators
    int         low_cnt [4];
    int         frame_low [8][4];
    int         seg_bad, dp_bad, off_bad, multi_bad, win_bad;
    logic [6:0] exp_seg [4];
    logic       exp_dp [4];
    int         exp_bright;

    localparam logic [6:0] G0 = 7'b0000001;
    localparam logic [6:0] G1 = 7'b1001111;
    localparam logic [6:0] GE = 7'b0110000;
    localparam logic [6:0] G8 = 7'b0000000;

    task automatic observe(input int ncyc);
        int s, tk, dd, f, nlow;
        for (int i = 0; i < 4; i++) begin
            low_cnt[i] = 0;
            for (int j = 0; j < 8; j++) frame_low[j][i] = 0;
        end
        seg_bad = 0; dp_bad = 0; off_bad = 0; multi_bad = 0; win_bad = 0;
        for (int c = 0; c < ncyc; c++) begin
            @(negedge clk);
            s    = s_cnt - 1;
            tk   = (s >> 1) & 15;
            dd   = (s >> 5) & 3;
            f    = (s >> 7) & 7;
            nlow = 0;
            for (int i = 0; i < 4; i++) begin
                if (dig[i] === 1'b0) begin
                    nlow++;
                    low_cnt[i]++;
                    frame_low[f][i]++;
                    if (seg !== exp_seg[i]) seg_bad++;
                    if (seg_dp !== exp_dp[i]) dp_bad++;
                    if (i != dd || tk < 1 || tk > exp_bright) win_bad++;
                end
            end
            if (nlow > 1) multi_bad++;
            if (nlow == 0 && (seg !== 7'h7F || seg_dp !== 1'b1)) off_bad++;
        end
    endtask

    task automatic bus_write(input logic [1:0] a, input logic [31:0] v);
        @(negedge clk);
        ctrl_address = a; ctrl_writedata = v; ctrl_write = 1'b1;
        @(negedge clk);
        ctrl_write = 1'b0;
    endtask

    task automatic bus_read(input logic [1:0] a, output logic [31:0] v);
        @(negedge clk);
        ctrl_address = a; ctrl_read = 1'b1;
        @(negedge clk);
        ctrl_read = 1'b0;
        v = ctrl_readdata;
    endtask

    // Advance to a sample whose frame phase is ph, at scan state >= min_s; bounded.
    task automatic wait_phase(input int ph, input int min_s);
        bit found = 1'b0;
        for (int c = 0; c < 600 && !found; c++) begin
            @(negedge clk);
            if (((s_cnt - 1) % 128) == ph && (s_cnt - 1) >= min_s) found = 1'b1;
        end
        checks++;
        if (!found) begin
            failures++;
            $display("FAIL wait_phase: phase %0d not reached, s=%0d", ph, s_cnt - 1);
        end
    endtask

    task automatic set_exp_all(input logic [6:0] g, input logic dp);
        for (int i = 0; i < 4; i++) begin
            exp_seg[i] = g;
            exp_dp[i]  = dp;
        end
    endtask

    task automatic test_reset();
        logic [31:0] v;
        logic [31:0] exp_rd [4];
        exp_rd[0] = 32'h0; exp_rd[1] = 32'hF; exp_rd[2] = 32'h0; exp_rd[3] = 32'hF;
        reset_n = 1'b0;
        repeat (3) @(negedge clk);
        checks++; if (dig !== 4'b1111) begin failures++; $display("FAIL reset_dig: got %b want 1111", dig); end
        checks++; if (seg !== 7'h7F) begin failures++; $display("FAIL reset_seg: got %h want 7f", seg); end
        checks++; if (seg_dp !== 1'b1) begin failures++; $display("FAIL reset_dp: got %b want 1", seg_dp); end
        checks++; if (ctrl_readdata !== 32'h0) begin failures++; $display("FAIL reset_rdata: got %h want 0", ctrl_readdata); end
        reset_n = 1'b1;
        for (int a = 0; a < 4; a++) begin
            bus_read(2'(a), v);
            checks++;
            if (v !== exp_rd[a]) begin failures++; $display("FAIL reset_reg%0d: got %h want %h", a, v, exp_rd[a]); end
        end
    endtask

    task automatic test_registers();
        logic [31:0] v;
        bus_write(2'd1, 32'hFFFF_FFFF);
        bus_read(2'd1, v);
        checks++; if (v !== 32'h0000_000F) begin failures++; $display("FAIL on_mask: got %h want 0000000f", v); end
        bus_write(2'd3, 32'hFFFF_F0FF);
        bus_read(2'd3, v);
        checks++; if (v !== 32'h0000_000F) begin failures++; $display("FAIL ctrl_mask: got %h want 0000000f", v); end
        bus_write(2'd0, 32'h8E10);
        // Same-cycle read and write of DP returns the old contents
        @(negedge clk);
        ctrl_address = 2'd2; ctrl_writedata = 32'h2; ctrl_write = 1'b1; ctrl_read = 1'b1;
        @(negedge clk);
        ctrl_write = 1'b0; ctrl_read = 1'b0;
        v = ctrl_readdata;
        checks++; if (v !== 32'h0) begin failures++; $display("FAIL rw_same_old: got %h want 0", v); end
        bus_read(2'd2, v);
        checks++; if (v !== 32'h2) begin failures++; $display("FAIL rw_same_new: got %h want 2", v); end
        bus_read(2'd0, v);
        checks++; if (v !== 32'h8E10) begin failures++; $display("FAIL data_rb: got %h want 8e10", v); end
    endtask

    task automatic test_decode();
        int exp_low [4];
        repeat (160) @(negedge clk);
        exp_seg[0] = G0; exp_seg[1] = G1; exp_seg[2] = GE; exp_seg[3] = G8;
        exp_dp[0] = 1'b1; exp_dp[1] = 1'b0; exp_dp[2] = 1'b1; exp_dp[3] = 1'b1;
        exp_bright = 15;
        observe(128);
        for (int i = 0; i < 4; i++) begin
            exp_low[i] = 30;
            checks++;
            if (low_cnt[i] !== exp_low[i]) begin failures++; $display("FAIL decode_duty%0d: got %0d want %0d", i, low_cnt[i], exp_low[i]); end
        end
        checks++; if (seg_bad !== 0) begin failures++; $display("FAIL decode_seg: %0d bad samples, want 0", seg_bad); end
        checks++; if (dp_bad !== 0) begin failures++; $display("FAIL decode_dp: %0d bad samples, want 0", dp_bad); end
        checks++; if (multi_bad !== 0) begin failures++; $display("FAIL decode_onehot: %0d multi-hot samples, want 0", multi_bad); end
        checks++; if (win_bad !== 0) begin failures++; $display("FAIL decode_window: %0d out-of-slot samples, want 0", win_bad); end
        checks++; if (off_bad !== 0) begin failures++; $display("FAIL decode_offlvl: %0d bad idle samples, want 0", off_bad); end
    endtask

    task automatic test_brightness();
        int total;
        bus_write(2'd3, 32'h3);
        repeat (4) @(negedge clk);
        exp_bright = 3;
        observe(128);
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (low_cnt[i] !== 6) begin failures++; $display("FAIL bright3_duty%0d: got %0d want 6", i, low_cnt[i]); end
        end
        checks++; if (win_bad !== 0) begin failures++; $display("FAIL bright3_window: %0d samples outside ticks 1-3, want 0", win_bad); end
        bus_write(2'd3, 32'h0);
        repeat (4) @(negedge clk);
        observe(128);
        total = low_cnt[0] + low_cnt[1] + low_cnt[2] + low_cnt[3];
        checks++; if (total !== 0) begin failures++; $display("FAIL bright0_dark: got %0d active samples want 0", total); end
        bus_write(2'd3, 32'hF);
        exp_bright = 15;
    endtask

    task automatic test_on_mask();
        int exp_low [4];
        exp_low[0] = 30; exp_low[1] = 0; exp_low[2] = 30; exp_low[3] = 0;
        bus_write(2'd1, 32'h5);
        repeat (160) @(negedge clk);
        observe(128);
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (low_cnt[i] !== exp_low[i]) begin failures++; $display("FAIL on_duty%0d: got %0d want %0d", i, low_cnt[i], exp_low[i]); end
        end
        checks++; if (seg_bad !== 0) begin failures++; $display("FAIL on_seg: %0d bad samples, want 0", seg_bad); end
        checks++; if (off_bad !== 0) begin failures++; $display("FAIL on_dark_dp: %0d bad idle samples, want 0", off_bad); end
        bus_write(2'd1, 32'hF);
    endtask

    task automatic test_blink();
        logic [7:0] dark0;
        int want;
        dark0 = 8'b1100_1100;   // frames 2,3,6,7 dark for digit 0
        @(negedge clk); reset_n = 1'b0;
        @(negedge clk); reset_n = 1'b1;
        bus_write(2'd3, 32'h010F);
        set_exp_all(G0, 1'b1);
        exp_bright = 15;
        observe(1024 - s_cnt);
        for (int f = 1; f < 8; f++) begin
            want = dark0[f] ? 0 : 30;
            checks++;
            if (frame_low[f][0] !== want) begin failures++; $display("FAIL blink_d0_f%0d: got %0d want %0d", f, frame_low[f][0], want); end
            for (int i = 1; i < 4; i++) begin
                checks++;
                if (frame_low[f][i] !== 30) begin failures++; $display("FAIL blink_d%0d_f%0d: got %0d want 30", i, f, frame_low[f][i]); end
            end
        end
        checks++; if (seg_bad !== 0) begin failures++; $display("FAIL blink_seg: %0d bad samples, want 0", seg_bad); end
    endtask

    task automatic test_midslot_write();
        int base;
        bus_write(2'd3, 32'h000F);
        wait_phase(10, 1100);
        base = (s_cnt - 1) - 10;
        bus_write(2'd0, 32'h0001);
        set_exp_all(G0, 1'b1);
        observe(base + 128 - s_cnt);
        checks++; if (low_cnt[0] < 10) begin failures++; $display("FAIL midslot_lit: got %0d want >=10", low_cnt[0]); end
        checks++; if (seg_bad !== 0) begin failures++; $display("FAIL midslot_hold: %0d changed samples, want 0", seg_bad); end
        exp_seg[0] = G1;
        observe(128);
        checks++; if (low_cnt[0] !== 30) begin failures++; $display("FAIL nextslot_duty: got %0d want 30", low_cnt[0]); end
        checks++; if (seg_bad !== 0) begin failures++; $display("FAIL nextslot_seg: %0d bad samples, want 0", seg_bad); end
    endtask

    task automatic test_async_reset();
        logic [31:0] v;
        bus_read(2'd0, v);
        checks++; if (v !== 32'h1) begin failures++; $display("FAIL pre_reset_rd: got %h want 1", v); end
        wait_phase(40, 0);
        checks++; if (dig !== 4'b1101) begin failures++; $display("FAIL pre_reset_dig: got %b want 1101", dig); end
        @(posedge clk);
        #2 reset_n = 1'b0;
        #1;
        checks++; if (dig !== 4'b1111) begin failures++; $display("FAIL async_dig: got %b want 1111", dig); end
        checks++; if (seg !== 7'h7F) begin failures++; $display("FAIL async_seg: got %h want 7f", seg); end
        checks++; if (seg_dp !== 1'b1) begin failures++; $display("FAIL async_dp: got %b want 1", seg_dp); end
        checks++; if (ctrl_readdata !== 32'h0) begin failures++; $display("FAIL async_rdata: got %h want 0", ctrl_readdata); end
        @(negedge clk); reset_n = 1'b1;
        @(negedge clk);
        checks++; if (dig !== 4'b1111) begin failures++; $display("FAIL restart_t0a: got %b want 1111", dig); end
        @(negedge clk);
        checks++; if (dig !== 4'b1111) begin failures++; $display("FAIL restart_t0b: got %b want 1111", dig); end
        @(negedge clk);
        checks++; if (dig !== 4'b1110) begin failures++; $display("FAIL restart_t1_dig: got %b want 1110", dig); end
        checks++; if (seg !== G0) begin failures++; $display("FAIL restart_t1_seg: got %b want %b", seg, G0); end
    endtask

    initial begin
        reset_n        = 1'b0;
        ctrl_address   = 2'd0;
        ctrl_write     = 1'b0;
        ctrl_writedata = 32'h0;
        ctrl_read      = 1'b0;
        exp_bright     = 15;
        set_exp_all(G0, 1'b1);
        test_reset();
        test_registers();
        test_decode();
        test_brightness();
        test_on_mask();
        test_blink();
        test_midslot_write();
        test_async_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/seg7led_dynamic.md
# seg7led_dynamic

Multiplexed (dynamic-drive) 7-segment LED driver for up to 8 digits sharing one segment bus. It sits on the system's 32-bit memory-mapped control bus beside the static driver and scans one digit at a time. It adds per-digit blanking, decimal points, 16-level PWM brightness, per-digit blinking, register readback, and an anti-ghosting blank interval at every digit change.

## Interface
- DIGITS, 4, number of scanned digits, 1..8
- SEG_ACTIVE_LOW, 1, 1 = segment/dp outputs drive 0 to light
- DIG_ACTIVE_LOW, 1, 1 = digit-select outputs drive 0 to enable
- PRESCALE, 1000, clk cycles per tick, >=1; one digit slot = 16 ticks
- BLINK_FRAMES, 64, full scan frames per blink half-period, >=1
- clk  in  1  system clock
- reset_n  in  1  asynchronous, active-low reset
- ctrl_address  in  2  register select
- ctrl_write  in  1  write strobe, one cycle
- ctrl_writedata  in  32  write data
- ctrl_read  in  1  read strobe
- ctrl_readdata  out  32  read data, read latency 1
- seg  out  7  segments, seg[6]=a .. seg[0]=g
- seg_dp  out  1  decimal point
- dig  out  DIGITS  one-hot digit select

## Operation
- Registers (bits above the listed fields read 0, writes ignored):
  - 0 DATA, [4*DIGITS-1:0], nibble i = hex value of digit i, reset 0
  - 1 ON, [DIGITS-1:0], reset all 1; 0 = digit dark, its dp also dark
  - 2 DP, [DIGITS-1:0], reset 0
  - 3 CTRL, [3:0] brightness, reset 15; [15:8] blink mask, reset 0 (bits at DIGITS and above read 0)
- Decode: standard hex glyphs 0-9, A, b, C, d, E, F. Lit segments for '0' are a..f; for '1' they are b, c; for '8' they are all.
- Counters: pc 0..PRESCALE-1; tick 0..15 increments when pc wraps; digit index d 0..DIGITS-1 increments when tick wraps 15->0; frame count and blink phase bp toggle every BLINK_FRAMES frames (a frame ends when d wraps).
- Slot sampling: at pc=0, tick=0 the glyph, dp, on bit and blink bit for digit d are latched into a slot register. Register writes never alter a slot in progress.
- Enable for the current slot is on_i & ~(blink_i & bp) & (1 <= tick <= brightness).
  - tick 0 is always blank (anti-ghost).
  - brightness 0 = fully dark.
  - brightness 15 = 15/16 duty.
- Outputs are registered:
  - dig = one-hot(d) when enabled, else all inactive.
  - seg and seg_dp carry the latched pattern when enabled, else all inactive (off level).
- Read: ctrl_readdata is loaded on the clock edge after ctrl_read and holds until the next read. Simultaneous read and write to the same address returns the old value.

## Timing
- Reset (asynchronous, immediate):
  - Outputs: dig, seg and seg_dp take their inactive levels; ctrl_readdata = 0.
  - Counters: pc, tick, d, frame count and bp all = 0.
- Reset mid-frame aborts the scan; after release, scanning restarts at digit 0, tick 0.
- Slot length 16*PRESCALE cycles; frame 16*PRESCALE*DIGITS cycles.
- Output latency: 1 clk after the counter state. dig[d] asserts 1 clk after tick becomes 1 and deasserts 1 clk after tick exceeds brightness or wraps to 0.
- A write takes effect at the next slot start of the affected digit (<= 1 frame + 1 slot).
- A brightness write takes effect on the next tick comparison, mid-slot allowed.
- A blink-mask write takes effect at the next slot latch; bp is unaffected by writes.
- DIGITS=1: d stays 0; each slot is a frame.

## Test plan
- DIGITS=4, PRESCALE=2, reset. Required response:
  - During reset: dig=4'b1111, seg=7'h7F, seg_dp=1.
  - After reset, reads of registers 0..3 return 0x0, 0xF, 0x0, 0xF.
- Write DATA=0x8E10, DP=0x2. Required response per slot:
  - Digit 0: seg=7'b0000001 (a..f lit, active-low).
  - Digit 1: seg=7'b1001111, seg_dp=0.
  - Digit 2: seg=7'b0110000.
  - Digit 3: seg=7'b0000000.
  - Each dig[i]=0 for exactly 30 of every 128 clocks.
  - dig is never 0 in more than one bit at once.
- Write CTRL brightness=3. Each digit is active for 6 clocks per slot, ticks 1-3 only. With brightness=0, dig stays 4'b1111 for a full frame.
- Write ON=0x5. Digits 1 and 3 stay dark with dp off; digits 0 and 2 are unchanged.
- BLINK_FRAMES=2, CTRL=0x010F. Digit 0 is dark in frames 2-3 and 6-7 (counting from 0) and lit otherwise; digits 1-3 are unaffected.
- Write DATA mid-slot of digit 0, then assert reset_n=0 mid-frame.
  - The write changes seg only from digit 0's next slot onward.
  - On reset, all outputs go inactive in the same cycle without waiting for clk.
